// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: scalar aliases, FSM/owner enums, latched request.
// Optional starvation guard is enabled with MEM_ARB_STARVE_EN.
package mem_arbiter_pkg;

   typedef logic [31:0] u32;
   typedef logic        u1;
   typedef logic [63:0] word_t;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} arb_state_t;
   typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} arb_owner_t;

   typedef struct packed {
      u32    addr;
      u1     we;
      word_t wdata;
   } mem_req_t;

   typedef logic [3:0] starve_cnt_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants made while a fetch waits; raises force_fetch once the limit is reached.
// Only instantiated when MEM_ARB_STARVE_EN is defined.
module mem_arb_starve_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_data,
   input  logic grant_instr,
   input  logic ireq_valid,
   output logic force_fetch
);

   localparam starve_cnt_t Limit = starve_cnt_t'(STARVE_LIMIT);

   starve_cnt_t cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_instr || (grant_data && !ireq_valid)) begin
         cnt_d = '0;
      end else if (grant_data && (cnt_q != '1)) begin
         cnt_d = cnt_q + starve_cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_fetch = (cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins by default.
// Define MEM_ARB_STARVE_EN to let a starved fetch win after STARVE_LIMIT data grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq_valid,
   input  logic [31:0] ireq_addr,
   output logic        ireq_ready,
   output logic        iresp_valid,
   output logic [31:0] iresp_data,
   input  logic        dreq_valid,
   input  logic [31:0] dreq_addr,
   input  logic        dreq_we,
   input  logic [63:0] dreq_wdata,
   output logic        dreq_ready,
   output logic        dresp_valid,
   output logic [63:0] dresp_data,
   output logic        mreq_valid,
   output logic [31:0] mreq_addr,
   output logic        mreq_we,
   output logic [63:0] mreq_wdata,
   input  logic        mreq_ready,
   input  logic        mresp_valid,
   input  logic [63:0] mresp_data
);

   arb_state_t state_q, state_d;
   arb_owner_t owner_q, owner_d;
   mem_req_t   req_q, req_d;

   logic        grant_data, grant_instr, force_fetch;
   logic        iresp_valid_q, iresp_valid_d;
   logic [31:0] iresp_data_q;
   logic        dresp_valid_q, dresp_valid_d;
   logic [63:0] dresp_data_q;

`ifdef MEM_ARB_STARVE_EN
   mem_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk         (clk),
      .reset       (reset),
      .grant_data  (grant_data),
      .grant_instr (grant_instr),
      .ireq_valid  (ireq_valid),
      .force_fetch (force_fetch)
   );
`else
   // No counter: a limit of zero would mean "always starved", anything legal means never.
   assign force_fetch = (starve_cnt_t'(STARVE_LIMIT) == '0);
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      req_d       = req_q;
      grant_data  = 1'b0;
      grant_instr = 1'b0;
      case (state_q)
         StIdle: begin
            if (dreq_valid && !(ireq_valid && force_fetch)) begin
               grant_data = 1'b1;
            end else if (ireq_valid) begin
               grant_instr = 1'b1;
            end
            if (grant_data) begin
               req_d   = '{addr: dreq_addr, we: dreq_we, wdata: dreq_wdata};
               owner_d = OwnData;
               state_d = StIssue;
            end else if (grant_instr) begin
               req_d   = '{addr: ireq_addr, we: 1'b0, wdata: '0};
               owner_d = OwnInstr;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (mreq_ready) state_d = StWait;
         end
         StWait: begin
            if (mresp_valid) begin
               owner_d = OwnNone;
               state_d = StIdle;
            end
         end
         default: begin
            owner_d = OwnNone;
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      iresp_valid_d = (state_q == StWait) && mresp_valid && (owner_q == OwnInstr);
      dresp_valid_d = (state_q == StWait) && mresp_valid && (owner_q == OwnData);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         owner_q       <= OwnNone;
         req_q         <= '0;
         iresp_valid_q <= 1'b0;
         iresp_data_q  <= '0;
         dresp_valid_q <= 1'b0;
         dresp_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         req_q         <= req_d;
         iresp_valid_q <= iresp_valid_d;
         dresp_valid_q <= dresp_valid_d;
         if (iresp_valid_d) iresp_data_q <= mresp_data[31:0];
         // Stores complete with zero data regardless of what memory drives.
         if (dresp_valid_d) dresp_data_q <= req_q.we ? '0 : mresp_data;
      end
   end

   assign ireq_ready  = grant_instr;
   assign dreq_ready  = grant_data;
   assign iresp_valid = iresp_valid_q;
   assign iresp_data  = iresp_data_q;
   assign dresp_valid = dresp_valid_q;
   assign dresp_data  = dresp_data_q;
   assign mreq_valid  = (state_q == StIssue);
   assign mreq_addr   = req_q.addr;
   assign mreq_we     = req_q.we;
   assign mreq_wdata  = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written corner cases.
// Grant-order expectations follow MEM_ARB_STARVE_EN when it is defined.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        ireq_ready;
   logic        iresp_valid;
   logic [31:0] iresp_data;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic        dreq_we;
   logic [63:0] dreq_wdata;
   logic        dreq_ready;
   logic        dresp_valid;
   logic [63:0] dresp_data;
   logic        mreq_valid;
   logic [31:0] mreq_addr;
   logic        mreq_we;
   logic [63:0] mreq_wdata;
   logic        mreq_ready;
   logic        mresp_valid;
   logic [63:0] mresp_data;

   int checks = 0;
   int errors = 0;
   logic        mem_auto;
   logic [63:0] mem_word;

   mem_arbiter #(
      .STARVE_LIMIT (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ireq_valid  (ireq_valid),
      .ireq_addr   (ireq_addr),
      .ireq_ready  (ireq_ready),
      .iresp_valid (iresp_valid),
      .iresp_data  (iresp_data),
      .dreq_valid  (dreq_valid),
      .dreq_addr   (dreq_addr),
      .dreq_we     (dreq_we),
      .dreq_wdata  (dreq_wdata),
      .dreq_ready  (dreq_ready),
      .dresp_valid (dresp_valid),
      .dresp_data  (dresp_data),
      .mreq_valid  (mreq_valid),
      .mreq_addr   (mreq_addr),
      .mreq_we     (mreq_we),
      .mreq_wdata  (mreq_wdata),
      .mreq_ready  (mreq_ready),
      .mresp_valid (mresp_valid),
      .mresp_data  (mresp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_data;
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [63:0] mdata;
      logic        exp_we;
      logic [63:0] exp_wdata;
      logic [63:0] exp_resp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle; memory answers one cycle after accepting a request when mem_auto is set.
   task automatic tick();
      logic p;
      p = mem_auto && mreq_valid && mreq_ready && !reset;
      @(posedge clk);
      @(negedge clk);
      mresp_valid = p;
      mresp_data  = p ? mem_word : 64'h0;
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ireq_ready"}, ireq_ready, 0);
      chk({tag, " dreq_ready"}, dreq_ready, 0);
      chk({tag, " iresp_valid"}, iresp_valid, 0);
      chk({tag, " iresp_data"}, iresp_data, 0);
      chk({tag, " dresp_valid"}, dresp_valid, 0);
      chk({tag, " dresp_data"}, dresp_data, 0);
      chk({tag, " mreq_valid"}, mreq_valid, 0);
      chk({tag, " mreq_addr"}, mreq_addr, 0);
      chk({tag, " mreq_we"}, mreq_we, 0);
      chk({tag, " mreq_wdata"}, mreq_wdata, 0);
   endtask

   initial begin
      reset = 1'b1; mem_auto = 1'b1; mreq_ready = 1'b1; mem_word = 64'h0;
      ireq_valid = 1'b0; ireq_addr = 32'h0;
      dreq_valid = 1'b0; dreq_addr = 32'h0; dreq_we = 1'b0; dreq_wdata = 64'h0;
      mresp_valid = 1'b0; mresp_data = 64'h0;

      vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0001,
                  1'b0, 64'h0, 64'hDEAD_BEEF_0000_0001};
      vecs[1] = '{1'b1, 32'h0000_0108, 1'b1, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b1, 64'h1122_3344_5566_7788, 64'h0};
      vecs[2] = '{1'b0, 32'h0000_0004, 1'b0, 64'h0, 64'hCAFE_BABE_1234_5678,
                  1'b0, 64'h0, 64'h0000_0000_1234_5678};
      vecs[3] = '{1'b1, 32'hFFFF_FFF8, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h0};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b0, 64'h0, 64'h0000_0000_FFFF_FFFF};

      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk_all_zero("reset");

      // Table: one transaction per record at minimum latency.
      for (int i = 0; i < 5; i++) begin
         mem_word = vecs[i].mdata;
         if (vecs[i].is_data) begin
            dreq_valid = 1'b1; dreq_addr = vecs[i].addr;
            dreq_we = vecs[i].we; dreq_wdata = vecs[i].wdata;
         end else begin
            ireq_valid = 1'b1; ireq_addr = vecs[i].addr;
         end
         #1;
         chk($sformatf("v%0d dreq_ready", i), dreq_ready, vecs[i].is_data);
         chk($sformatf("v%0d ireq_ready", i), ireq_ready, !vecs[i].is_data);
         tick();
         dreq_valid = 1'b0; ireq_valid = 1'b0;
         chk($sformatf("v%0d mreq_valid", i), mreq_valid, 1);
         chk($sformatf("v%0d mreq_addr", i), mreq_addr, vecs[i].addr);
         chk($sformatf("v%0d mreq_we", i), mreq_we, vecs[i].exp_we);
         chk($sformatf("v%0d mreq_wdata", i), mreq_wdata, vecs[i].exp_wdata);
         tick();
         chk($sformatf("v%0d mreq_valid wait", i), mreq_valid, 0);
         tick();
         chk($sformatf("v%0d dresp_valid", i), dresp_valid, vecs[i].is_data);
         chk($sformatf("v%0d iresp_valid", i), iresp_valid, !vecs[i].is_data);
         if (vecs[i].is_data) chk($sformatf("v%0d dresp_data", i), dresp_data, vecs[i].exp_resp);
         else chk($sformatf("v%0d iresp_data", i), iresp_data, vecs[i].exp_resp);
         if (i == 3) chk("iresp_data held", iresp_data, 32'h1234_5678);
         tick();
         chk($sformatf("v%0d dresp pulse end", i), dresp_valid, 0);
         chk($sformatf("v%0d iresp pulse end", i), iresp_valid, 0);
      end

      // Simultaneous fetch and store: data first, fetch granted in the response cycle.
      mem_word = 64'h0123_4567_89AB_CDEF;
      ireq_valid = 1'b1; ireq_addr = 32'h0;
      dreq_valid = 1'b1; dreq_addr = 32'h200; dreq_we = 1'b1; dreq_wdata = 64'h55;
      #1;
      chk("conf dreq_ready", dreq_ready, 1);
      chk("conf ireq_ready", ireq_ready, 0);
      tick();
      dreq_valid = 1'b0; dreq_we = 1'b0; dreq_wdata = 64'h0;
      chk("conf mreq_we", mreq_we, 1);
      chk("conf mreq_addr", mreq_addr, 32'h200);
      chk("conf mreq_wdata", mreq_wdata, 64'h55);
      chk("conf ireq_ready issue", ireq_ready, 0);
      tick();
      chk("conf ireq_ready wait", ireq_ready, 0);
      tick();
      chk("conf dresp_valid", dresp_valid, 1);
      chk("conf dresp_data", dresp_data, 64'h0);
      chk("conf ireq_ready c3", ireq_ready, 1);
      tick();
      ireq_valid = 1'b0;
      chk("conf fetch mreq_addr", mreq_addr, 32'h0);
      chk("conf fetch mreq_we", mreq_we, 0);
      chk("conf fetch mreq_wdata", mreq_wdata, 64'h0);
      tick();
      tick();
      chk("conf iresp_valid", iresp_valid, 1);
      chk("conf iresp_data", iresp_data, 32'h89AB_CDEF);
      chk("conf dresp_valid low", dresp_valid, 0);
      tick();

      // Backpressure: request must sit stable in ISSUE while a fetch waits unacknowledged.
      mem_word = 64'hA5A5_0000_1111_2222;
      mreq_ready = 1'b0;
      dreq_valid = 1'b1; dreq_addr = 32'h300; dreq_we = 1'b0; dreq_wdata = 64'h0;
      ireq_valid = 1'b1; ireq_addr = 32'h40;
      #1;
      chk("bp dreq_ready", dreq_ready, 1);
      tick();
      dreq_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d mreq_valid", k), mreq_valid, 1);
         chk($sformatf("bp%0d mreq_addr", k), mreq_addr, 32'h300);
         chk($sformatf("bp%0d mreq_we", k), mreq_we, 0);
         chk($sformatf("bp%0d mreq_wdata", k), mreq_wdata, 64'h0);
         chk($sformatf("bp%0d ready", k), {ireq_ready, dreq_ready}, 2'b00);
         tick();
      end
      mreq_ready = 1'b1;
      tick();
      tick();
      chk("bp dresp_valid", dresp_valid, 1);
      chk("bp dresp_data", dresp_data, 64'hA5A5_0000_1111_2222);
      chk("bp ireq_ready", ireq_ready, 1);
      tick();
      ireq_valid = 1'b0;
      tick();
      tick();
      chk("bp iresp_data", iresp_data, 32'h1111_2222);
      tick();

      // Both requesters held valid: grant order depends on the starvation guard.
      ireq_valid = 1'b1; ireq_addr = 32'h80;
      dreq_valid = 1'b1; dreq_addr = 32'h500; dreq_we = 1'b0; dreq_wdata = 64'h0;
      #1;
      for (int g = 0; g < 6; g++) begin
         logic got, exp_instr;
`ifdef MEM_ARB_STARVE_EN
         exp_instr = ((g % 3) == 2);
`else
         exp_instr = 1'b0;
`endif
         got = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            if (ireq_ready || dreq_ready) begin
               chk($sformatf("starve g%0d one ready", g), ireq_ready & dreq_ready, 0);
               chk($sformatf("starve g%0d instr grant", g), ireq_ready, exp_instr);
               got = 1'b1;
            end
            tick();
         end
         if (!got) chk($sformatf("starve g%0d grant seen", g), 0, 1);
      end
      ireq_valid = 1'b0; dreq_valid = 1'b0;
      tick();
      tick();
      tick();

      // Reset while waiting for memory: the late response must be dropped.
      mem_auto = 1'b0;
      dreq_valid = 1'b1; dreq_addr = 32'h700;
      #1;
      chk("rst dreq_ready", dreq_ready, 1);
      tick();
      dreq_valid = 1'b0;
      tick();
      chk("rst in wait", mreq_valid, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all_zero("rst after");
      mresp_valid = 1'b1; mresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      chk("rst no dresp", dresp_valid, 0);
      chk("rst no iresp", iresp_valid, 0);
      chk("rst dresp_data", dresp_data, 0);
      mem_auto = 1'b1;
      mem_word = 64'h0000_0000_0000_0777;
      dreq_valid = 1'b1; dreq_addr = 32'h600;
      #1;
      chk("rst next dreq_ready", dreq_ready, 1);
      tick();
      dreq_valid = 1'b0;
      chk("rst next mreq_addr", mreq_addr, 32'h600);
      tick();
      tick();
      chk("rst next dresp_valid", dresp_valid, 1);
      chk("rst next dresp_data", dresp_data, 64'h777);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
